oram_path_ctrl: RTL and testbench
=================================

ORAM_PATH_CTRL -- requirements
Module: oram_path_ctrl

Interface
REQ-001 SHALL have parameter MAX_ORAM_L, default 32, leaf-index width.
REQ-002 SHALL have parameter MAX_LOG_L, default 5, width of ORAMLevels.
REQ-003 SHALL have parameter DRAM_ADDR_WIDTH, default 30, command address width.
REQ-004 SHALL have parameter BKT_CHUNKS, default 4, DRAM commands per bucket (>=1).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 8, max in-flight read commands (>=1).
REQ-006 SHALL have port Clock  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port ORAMLevels  input  MAX_LOG_L  tree depth L; path = L+1 buckets; sampled at request accept.
REQ-009 SHALL have ports ReqValid input 1, ReqReady output 1  access request handshake.
REQ-010 SHALL have port ReqLeaf  input  MAX_ORAM_L  leaf label; only bits [L-1:0] used.
REQ-011 SHALL have port ReqDummy  input  1  dummy-access flag, captured with request.
REQ-012 SHALL have ports CmdValid output 1, CmdReady input 1  memory command handshake.
REQ-013 SHALL have port CmdRead  output  1  1 = read, 0 = write.
REQ-014 SHALL have port CmdAddr  output  DRAM_ADDR_WIDTH  chunk address.
REQ-015 SHALL have port RdBeat  input  1  one pulse per returned read chunk.
REQ-016 SHALL have port WrBeat  input  1  one pulse per completed write chunk.
REQ-017 SHALL have ports Busy output 1, Done output 1, DoneDummy output 1  status.

Function
REQ-018 SHALL implement states IDLE, READ, READ_WAIT, WRITE, WRITE_WAIT, DONE.
REQ-019 SHALL assert ReqReady only in IDLE; accept on ReqValid&ReqReady, latch leaf, dummy, L; go to READ.
REQ-020 SHALL compute bucket heap index at level l as (2^l - 1) + (leaf[L-1:0] >> (L-l)); L=0 gives root only.
REQ-021 SHALL form CmdAddr = heapIdx*BKT_CHUNKS + chunk, truncated modulo 2^DRAM_ADDR_WIDTH.
REQ-022 SHALL in READ issue reads level 0..L, chunks 0..BKT_CHUNKS-1 ascending; CmdValid high first cycle after accept.
REQ-023 SHALL hold CmdValid/CmdRead/CmdAddr stable until CmdReady; advance one chunk per handshake.
REQ-024 SHALL deassert CmdValid in READ while outstanding reads == MAX_OUTSTANDING; outstanding +1 on read handshake, -1 on RdBeat, net 0 when same cycle.
REQ-025 SHALL go READ->READ_WAIT after last read handshake; READ_WAIT->WRITE when received RdBeat count == (L+1)*BKT_CHUNKS.
REQ-026 SHALL in WRITE issue writes level L down to 0, chunks ascending within bucket; CmdRead=0.
REQ-027 SHALL go WRITE->WRITE_WAIT after last write handshake; WRITE_WAIT->DONE when WrBeat count == (L+1)*BKT_CHUNKS.
REQ-028 SHALL in DONE pulse Done for one cycle, DoneDummy = latched ReqDummy, then return to IDLE.
REQ-029 SHALL issue identical command sequences for dummy and real accesses (oblivious traffic).
REQ-030 SHALL assert Busy in every state except IDLE.
REQ-031 SHALL ignore RdBeat outside READ/READ_WAIT and WrBeat outside WRITE/WRITE_WAIT; counters never underflow or exceed total.
REQ-032 SHALL ignore ORAMLevels changes after accept; ReqValid during Busy is not accepted.

Reset
REQ-033 SHALL on Reset force IDLE, ReqReady=1, CmdValid=0, Busy=0, Done=0, DoneDummy=0, counters 0, CmdAddr=0, CmdRead=0.
REQ-034 SHALL on Reset mid-access abandon access with no Done pulse; next cycle accepts a new request.

Verification
REQ-035 SHALL verify L=2, BKT_CHUNKS=2, leaf=2, CmdReady=1, beats prompt -> reads 0,1,4,5,10,11 then writes 10,11,4,5,0,1, one Done.
REQ-036 SHALL verify MAX_OUTSTANDING=2, RdBeat withheld -> exactly 2 reads issued, CmdValid low until RdBeat.
REQ-037 SHALL verify CmdReady low 5 cycles mid-read -> CmdAddr/CmdRead stable, no skipped or repeated address.
REQ-038 SHALL verify ReqDummy=1 -> same command sequence as real, Done=1 with DoneDummy=1.
REQ-039 SHALL verify L=0, leaf=0 -> reads 0..BKT_CHUNKS-1, writes same, Done after BKT_CHUNKS WrBeats.
REQ-040 SHALL verify Reset during WRITE_WAIT -> IDLE next cycle, no Done, new request accepted at leaf 0 correctly.

Source files
------------

// File: rtl/oram_path_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oram_path_ctrl
// Brief    : Path ORAM access sequencer. Accepts one access (leaf, dummy
//            flag), reads every bucket on the root-to-leaf path in chunk
//            order, waits for all read data, writes the path back leaf-to-
//            root, waits for all write acknowledgements and signals Done.
//            Dummy and real accesses produce identical memory traffic.
// Revision : 1.0 - initial release
// ============================================================================
module oram_path_ctrl #(
   parameter int MAX_ORAM_L      = 32,
   parameter int MAX_LOG_L       = 5,
   parameter int DRAM_ADDR_WIDTH = 30,
   parameter int BKT_CHUNKS      = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic [MAX_LOG_L-1:0]       ORAMLevels,
   input  logic                       ReqValid,
   output logic                       ReqReady,
   input  logic [MAX_ORAM_L-1:0]      ReqLeaf,
   input  logic                       ReqDummy,
   output logic                       CmdValid,
   input  logic                       CmdReady,
   output logic                       CmdRead,
   output logic [DRAM_ADDR_WIDTH-1:0] CmdAddr,
   input  logic                       RdBeat,
   input  logic                       WrBeat,
   output logic                       Busy,
   output logic                       Done,
   output logic                       DoneDummy
);

   localparam int c_CHUNK_W = (BKT_CHUNKS > 1) ? $clog2(BKT_CHUNKS) : 1;
   localparam int c_OUT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_CNT_W   = MAX_LOG_L + 1 + c_CHUNK_W;
   localparam int c_HEAP_W  = MAX_ORAM_L + 1;

   localparam logic [c_CHUNK_W-1:0] c_LAST_CHUNK = c_CHUNK_W'(BKT_CHUNKS - 1);
   localparam logic [c_OUT_W-1:0]   c_MAX_OUT    = c_OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_READ       = 3'd1,
      S_READ_WAIT  = 3'd2,
      S_WRITE      = 3'd3,
      S_WRITE_WAIT = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t                  r_state;
   state_t                  w_nextState;

   logic [MAX_ORAM_L-1:0]   r_leaf;
   logic [MAX_LOG_L-1:0]    r_levels;
   logic                    r_dummy;
   logic [MAX_LOG_L-1:0]    r_level;
   logic [c_CHUNK_W-1:0]    r_chunk;
   logic [c_OUT_W-1:0]      r_outstanding;
   logic [c_CNT_W-1:0]      r_beatCnt;
   logic [c_CNT_W-1:0]      r_total;

   logic                    w_cmdFire;
   logic                    w_lastChunk;
   logic                    w_lastRdCmd;
   logic                    w_lastWrCmd;
   logic                    w_rdPhase;
   logic                    w_wrPhase;
   logic                    w_rdInc;
   logic                    w_rdDec;
   logic                    w_beatCount;
   logic [c_CNT_W-1:0]      w_reqTotal;
   logic [c_HEAP_W-1:0]     w_leafMask;
   logic [c_HEAP_W-1:0]     w_leafLow;
   logic [c_HEAP_W-1:0]     w_heapIdx;

   assign w_cmdFire   = CmdValid & CmdReady;
   assign w_lastChunk = (r_chunk == c_LAST_CHUNK);
   assign w_lastRdCmd = w_lastChunk && (r_level == r_levels);
   assign w_lastWrCmd = w_lastChunk && (r_level == '0);
   assign w_rdPhase   = (r_state == S_READ) || (r_state == S_READ_WAIT);
   assign w_wrPhase   = (r_state == S_WRITE) || (r_state == S_WRITE_WAIT);
   assign w_rdInc     = w_cmdFire && (r_state == S_READ);
   assign w_rdDec     = RdBeat && w_rdPhase && (r_outstanding != '0);
   assign w_beatCount = ((RdBeat && w_rdPhase) || (WrBeat && w_wrPhase)) && (r_beatCnt != r_total);
   assign w_reqTotal  = (c_CNT_W'(ORAMLevels) + c_CNT_W'(1)) * c_CNT_W'(BKT_CHUNKS);

   // Heap index of the bucket at the current level: nodes above this level
   // plus the leaf's top r_level bits (leaf truncated to the tree depth).
   assign w_leafMask  = ~({c_HEAP_W{1'b1}} << r_levels);
   assign w_leafLow   = {1'b0, r_leaf} & w_leafMask;
   assign w_heapIdx   = ((c_HEAP_W'(1) << r_level) - c_HEAP_W'(1))
                      + (w_leafLow >> (r_levels - r_level));
   assign CmdAddr     = DRAM_ADDR_WIDTH'(w_heapIdx) * DRAM_ADDR_WIDTH'(BKT_CHUNKS)
                      + DRAM_ADDR_WIDTH'(r_chunk);

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode and per-state handshake/status outputs.
   always_comb begin
      w_nextState = r_state;
      ReqReady    = 1'b0;
      CmdValid    = 1'b0;
      CmdRead     = 1'b0;
      Busy        = 1'b1;
      Done        = 1'b0;
      DoneDummy   = 1'b0;
      case (r_state)
         S_IDLE: begin
            ReqReady = 1'b1;
            Busy     = 1'b0;
            if (ReqValid) begin
               w_nextState = S_READ;
            end
         end
         S_READ: begin
            CmdRead  = 1'b1;
            CmdValid = (r_outstanding != c_MAX_OUT);
            if (CmdValid && CmdReady && w_lastRdCmd) begin
               w_nextState = S_READ_WAIT;
            end
         end
         S_READ_WAIT: begin
            if (r_beatCnt == r_total) begin
               w_nextState = S_WRITE;
            end
         end
         S_WRITE: begin
            CmdValid = 1'b1;
            if (CmdReady && w_lastWrCmd) begin
               w_nextState = S_WRITE_WAIT;
            end
         end
         S_WRITE_WAIT: begin
            if (r_beatCnt == r_total) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            Done        = 1'b1;
            DoneDummy   = r_dummy;
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Request capture, path walk pointer, in-flight read and beat counters.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_leaf        <= '0;
         r_levels      <= '0;
         r_dummy       <= 1'b0;
         r_level       <= '0;
         r_chunk       <= '0;
         r_outstanding <= '0;
         r_beatCnt     <= '0;
         r_total       <= '0;
      end else if (r_state == S_IDLE) begin
         if (ReqValid) begin
            r_leaf        <= ReqLeaf;
            r_levels      <= ORAMLevels;
            r_dummy       <= ReqDummy;
            r_level       <= '0;
            r_chunk       <= '0;
            r_outstanding <= '0;
            r_beatCnt     <= '0;
            r_total       <= w_reqTotal;
         end
      end else begin
         // Walk the path: root-to-leaf for reads, leaf-to-root for writes.
         // At the final bucket the level is left in place, which for reads
         // is exactly the starting level of the write-back.
         if (w_cmdFire) begin
            if (w_lastChunk) begin
               r_chunk <= '0;
               if ((r_state == S_READ) && (r_level != r_levels)) begin
                  r_level <= r_level + MAX_LOG_L'(1);
               end else if ((r_state == S_WRITE) && (r_level != '0)) begin
                  r_level <= r_level - MAX_LOG_L'(1);
               end
            end else begin
               r_chunk <= r_chunk + c_CHUNK_W'(1);
            end
         end

         if (w_rdInc && !w_rdDec) begin
            r_outstanding <= r_outstanding + c_OUT_W'(1);
         end else if (!w_rdInc && w_rdDec) begin
            r_outstanding <= r_outstanding - c_OUT_W'(1);
         end

         // One counter serves both phases; it restarts when writes begin.
         if ((r_state == S_READ_WAIT) && (w_nextState == S_WRITE)) begin
            r_beatCnt <= '0;
         end else if (w_beatCount) begin
            r_beatCnt <= r_beatCnt + c_CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oram_path_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_oram_path_ctrl
// Brief    : Self-checking bench for oram_path_ctrl. A memory responder
//            returns beats for issued commands; the observed command stream
//            is compared with a path list computed from leaf arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oram_path_ctrl;

   localparam int LW = 8;
   localparam int LLW = 3;
   localparam int AW = 30;
   localparam int BK = 2;
   localparam int MO = 2;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [LLW-1:0] ORAMLevels;
   logic          ReqValid;
   logic          ReqReady;
   logic [LW-1:0] ReqLeaf;
   logic          ReqDummy;
   logic          CmdValid;
   logic          CmdReady;
   logic          CmdRead;
   logic [AW-1:0] CmdAddr;
   logic          RdBeat;
   logic          WrBeat;
   logic          Busy;
   logic          Done;
   logic          DoneDummy;

   oram_path_ctrl #(
      .MAX_ORAM_L(LW), .MAX_LOG_L(LLW), .DRAM_ADDR_WIDTH(AW),
      .BKT_CHUNKS(BK), .MAX_OUTSTANDING(MO)
   ) dut (
      .Clock(Clock), .Reset(Reset), .ORAMLevels(ORAMLevels),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqLeaf(ReqLeaf),
      .ReqDummy(ReqDummy), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .CmdRead(CmdRead), .CmdAddr(CmdAddr), .RdBeat(RdBeat),
      .WrBeat(WrBeat), .Busy(Busy), .Done(Done), .DoneDummy(DoneDummy)
   );

   // Free-running clock.
   always #5 Clock = ~Clock;

   int  checks = 0;
   int  errors = 0;
   int  obsAddr[$];
   bit  obsRd[$];
   int  expAddr[$];
   bit  expRd[$];
   int  pendRd, pendWr, maxInfl, doneCnt, wrBeatsSent, doneAtWr;
   int  readsFired, writesFired, curTotal, stallAt, stallLeft, prevAddr;
   bit  doneDummySeen, curDummy, prevStall, prevRead;
   bit  holdRd, holdWr, rdyRand, beatRand, spurious;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference path: bucket at level l is the l-th ancestor of the leaf in
   // a heap-numbered complete binary tree of depth L.
   function automatic void buildExp(input int L, input int leaf);
      int lf, idx;
      expAddr.delete();
      expRd.delete();
      lf = leaf % (1 << L);
      for (int l = 0; l <= L; l++) begin
         idx = (1 << l) - 1 + lf / (1 << (L - l));
         for (int c = 0; c < BK; c++) begin
            expAddr.push_back(idx * BK + c);
            expRd.push_back(1'b1);
         end
      end
      for (int l = L; l >= 0; l--) begin
         idx = (1 << l) - 1 + lf / (1 << (L - l));
         for (int c = 0; c < BK; c++) begin
            expAddr.push_back(idx * BK + c);
            expRd.push_back(1'b0);
         end
      end
   endfunction

   // One clock: drive responder inputs at negedge, sample 1ns later.
   task automatic step();
      bit realRd, realWr;
      @(negedge Clock);
      if (stallLeft > 0 && readsFired >= stallAt) begin
         CmdReady = 1'b0;
         stallLeft--;
      end else begin
         CmdReady = rdyRand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      realRd = (pendRd > 0) && !holdRd && (!beatRand || $urandom_range(0, 2) == 0);
      realWr = (pendWr > 0) && !holdWr && (!beatRand || $urandom_range(0, 2) == 0);
      RdBeat = realRd;
      WrBeat = realWr;
      if (!realRd && spurious && writesFired > 0 && pendRd == 0 && $urandom_range(0, 3) == 0)
         RdBeat = 1'b1;
      if (!realWr && spurious && readsFired < curTotal && $urandom_range(0, 3) == 0)
         WrBeat = 1'b1;
      #1;
      if (prevStall) begin
         chk("stallValid", CmdValid, 1);
         chk("stallAddr", CmdAddr, prevAddr);
         chk("stallRead", CmdRead, prevRead);
      end
      prevStall = CmdValid && !CmdReady;
      prevAddr  = int'(CmdAddr);
      prevRead  = CmdRead;
      if (CmdValid && CmdReady) begin
         obsAddr.push_back(int'(CmdAddr));
         obsRd.push_back(CmdRead);
         if (CmdRead) begin
            readsFired++;
            pendRd++;
         end else begin
            writesFired++;
            pendWr++;
         end
      end
      if (realRd) pendRd--;
      if (realWr) begin
         pendWr--;
         wrBeatsSent++;
      end
      if (pendRd > maxInfl) maxInfl = pendRd;
      if (Done) begin
         doneCnt++;
         doneDummySeen = DoneDummy;
         doneAtWr = wrBeatsSent;
      end
   endtask

   task automatic startReq(input int L, input int leaf, input bit dummy);
      obsAddr.delete();
      obsRd.delete();
      pendRd = 0; pendWr = 0; maxInfl = 0; doneCnt = 0; wrBeatsSent = 0;
      doneAtWr = 0; readsFired = 0; writesFired = 0; prevStall = 1'b0;
      curTotal = (L + 1) * BK;
      curDummy = dummy;
      buildExp(L, leaf);
      ORAMLevels = LLW'(L);
      ReqLeaf    = LW'(leaf);
      ReqDummy   = dummy;
      ReqValid   = 1'b1;
      step();
      chk("busyAfterAccept", Busy, 1);
      chk("reqReadyBusy", ReqReady, 0);
      chk("firstCmdValid", CmdValid, 1);
      ReqValid   = 1'b0;
      ORAMLevels = LLW'($urandom);
      ReqLeaf    = LW'($urandom);
      ReqDummy   = ~dummy;
   endtask

   task automatic finishAccess(input int budget);
      int n = 0;
      while (doneCnt == 0 && n < budget) begin
         ReqValid   = 1'($urandom_range(0, 1));
         ORAMLevels = LLW'($urandom);
         step();
         n++;
      end
      ReqValid = 1'b0;
      if (doneCnt == 0) chk("doneTimeout", n, -1);
      repeat (3) step();
      chk("doneCount", doneCnt, 1);
      chk("doneDummy", doneDummySeen, curDummy);
      chk("wrBeatsAtDone", doneAtWr, curTotal);
      chk("inflightLimit", maxInfl <= MO, 1);
      chk("idleAfter", Busy, 0);
      chk("numCmds", obsAddr.size(), expAddr.size());
      for (int i = 0; i < obsAddr.size() && i < expAddr.size(); i++)
         chk($sformatf("cmd%0d(rd*2^32+addr)", i),
             (longint'(obsRd[i]) << 32) | longint'(obsAddr[i]),
             (longint'(expRd[i]) << 32) | longint'(expAddr[i]));
   endtask

   // Scenario sequencer.
   initial begin
      int n;
      Reset = 1'b1; ORAMLevels = '0; ReqValid = 1'b0; ReqLeaf = '0; ReqDummy = 1'b0;
      CmdReady = 1'b0; RdBeat = 1'b0; WrBeat = 1'b0;
      holdRd = 0; holdWr = 0; rdyRand = 0; beatRand = 0; spurious = 0;
      stallAt = 0; stallLeft = 0; curTotal = 0; pendRd = 0; pendWr = 0;
      readsFired = 0; writesFired = 0; prevStall = 0;
      step();
      step();
      chk("rstReqReady", ReqReady, 1);
      chk("rstCmdValid", CmdValid, 0);
      chk("rstBusy", Busy, 0);
      chk("rstDone", Done, 0);
      chk("rstDoneDummy", DoneDummy, 0);
      chk("rstCmdAddr", CmdAddr, 0);
      chk("rstCmdRead", CmdRead, 0);
      prevStall = 1'b0;
      Reset = 1'b0;
      step();

      // Basic path, L=2 leaf=2: reads 0,1,4,5,10,11 then writes reversed.
      startReq(2, 2, 1'b0);
      finishAccess(300);

      // Read data withheld: only MAX_OUTSTANDING reads may be in flight.
      holdRd = 1'b1;
      startReq(3, 5, 1'b0);
      repeat (8) step();
      chk("heldReadsIssued", readsFired, MO);
      chk("heldCmdValid", CmdValid, 0);
      holdRd = 1'b0;
      step();
      step();
      chk("resumeCmdValid", CmdValid, 1);
      finishAccess(300);

      // Five-cycle CmdReady stall after two reads.
      stallAt = 2; stallLeft = 5;
      startReq(2, 1, 1'b0);
      finishAccess(300);

      // Dummy access: same traffic as the real one, DoneDummy set.
      startReq(2, 2, 1'b1);
      finishAccess(300);

      // Root-only tree.
      startReq(0, 0, 1'b0);
      finishAccess(300);

      // Reset while waiting for write acknowledgements.
      holdWr = 1'b1;
      startReq(2, 3, 1'b0);
      n = 0;
      while (writesFired < curTotal && n < 300) begin
         step();
         n++;
      end
      chk("allWritesIssued", writesFired, curTotal);
      step();
      step();
      Reset = 1'b1;
      step();
      chk("midRstBusy", Busy, 0);
      chk("midRstReqReady", ReqReady, 1);
      chk("midRstCmdValid", CmdValid, 0);
      chk("midRstNoDone", doneCnt, 0);
      Reset = 1'b0;
      holdWr = 1'b0;
      prevStall = 1'b0;
      startReq(2, 0, 1'b0);
      finishAccess(300);

      // Randomized accesses with random backpressure, beat timing and
      // beats arriving in phases where they must be ignored.
      rdyRand = 1'b1; beatRand = 1'b1; spurious = 1'b1;
      repeat (10) begin
         startReq($urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
         finishAccess(2000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
